// File: rtl/slot_pkg.sv
// Shared types and constants for the slot-machine display slice.
package slot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    ROLL
  } cd_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9.
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic int unsigned CREDIT_MAX(input int unsigned digits);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary to BCD converter, one input bit per cycle.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W);

  logic [BIN_W-1:0]    sr_q;
  logic [4*DIGITS-1:0] acc_q;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] shifted;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;

  always_comb begin
    adj = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj[4*DIGITS-2:0], sr_q[BIN_W-1]};
  end

  // After BIN_W shifts one extra cycle publishes done, so acc_q is stable when sampled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        if (cnt_q == CNT_LAST) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          acc_q <= shifted;
          sr_q  <= {sr_q[BIN_W-2:0], 1'b0};
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else if (start) begin
        sr_q   <= bin;
        acc_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = acc_q;

endmodule

// File: rtl/credit_display.sv
// Credit total holder with win roll-up, BCD conversion and multiplexed
// active-low 7-segment drive.
module credit_display #(
  parameter int unsigned CREDIT_W    = 10,
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned REFRESH_DIV = 25000,
  parameter int unsigned ROLL_DIV    = 1250000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CREDIT_W-1:0] total_credits,
  input  logic                is_total,
  input  logic [CREDIT_W-1:0] win_credits,
  input  logic                is_win,
  input  logic                spin_done,
  output logic [6:0]          seven_segment_output,
  output logic [DIGITS-1:0]   digit_en,
  output logic                win_active
);
  import slot_pkg::*;

  localparam int unsigned RC_W = (ROLL_DIV > 1) ? $clog2(ROLL_DIV) : 1;
  localparam int unsigned RF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CREDIT_W-1:0] CMAX      = CREDIT_W'(CREDIT_MAX(DIGITS));
  localparam logic [RC_W-1:0]     ROLL_LAST = RC_W'(ROLL_DIV - 1);
  localparam logic [RF_W-1:0]     REF_LAST  = RF_W'(REFRESH_DIV - 1);
  localparam logic [IX_W-1:0]     IDX_LAST  = IX_W'(DIGITS - 1);

  cd_state_t           state_q, state_d;
  logic [CREDIT_W-1:0] target_q, target_d;
  logic [CREDIT_W-1:0] shown_q, shown_d;
  logic [CREDIT_W-1:0] clamped, tgt_eff, shown_inc;
  logic                win_pending_q, win_pending_d;
  logic                done_seen_q, done_seen_d;
  logic                spin_q, spin_rise, pend_eff, snap;
  logic [RC_W-1:0]     roll_cnt_q, roll_cnt_d;
  logic                win_active_q;

  // A same-cycle win is folded into pend_eff so the accompanying total counts as a winning total.
  always_comb begin
    clamped       = (total_credits > CMAX) ? CMAX : total_credits;
    spin_rise     = spin_done & ~spin_q;
    pend_eff      = win_pending_q | (is_win & (win_credits != '0));
    tgt_eff       = is_total ? clamped : target_q;
    shown_inc     = shown_q + CREDIT_W'(1);
    snap          = is_total && (clamped < shown_q) && (state_q != IDLE);
    state_d       = state_q;
    target_d      = target_q;
    shown_d       = shown_q;
    win_pending_d = pend_eff;
    done_seen_d   = spin_rise | (done_seen_q & ~is_win);
    roll_cnt_d    = roll_cnt_q;
    if (snap) begin
      target_d      = clamped;
      shown_d       = clamped;
      win_pending_d = 1'b0;
      state_d       = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_total) begin
            target_d = clamped;
            if (pend_eff && (clamped > shown_q)) begin
              state_d = HOLD;
            end else begin
              shown_d       = clamped;
              win_pending_d = 1'b0;
            end
          end
        end
        HOLD: begin
          target_d = tgt_eff;
          if (done_seen_q) begin
            roll_cnt_d = '0;
            state_d    = ROLL;
          end
        end
        ROLL: begin
          target_d = tgt_eff;
          if (shown_q == tgt_eff) begin
            state_d       = IDLE;
            win_pending_d = 1'b0;
            done_seen_d   = 1'b0;
          end else if (roll_cnt_q == ROLL_LAST) begin
            roll_cnt_d = '0;
            shown_d    = shown_inc;
            if (shown_inc == tgt_eff) begin
              state_d       = IDLE;
              win_pending_d = 1'b0;
              done_seen_d   = 1'b0;
            end
          end else begin
            roll_cnt_d = roll_cnt_q + RC_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      target_q      <= '0;
      shown_q       <= '0;
      win_pending_q <= 1'b0;
      done_seen_q   <= 1'b0;
      spin_q        <= 1'b0;
      roll_cnt_q    <= '0;
      win_active_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      shown_q       <= shown_d;
      win_pending_q <= win_pending_d;
      done_seen_q   <= done_seen_d;
      spin_q        <= spin_done;
      roll_cnt_q    <= roll_cnt_d;
      win_active_q  <= (state_d != IDLE);
    end
  end

  logic                conv_start, conv_busy, conv_done;
  logic [4*DIGITS-1:0] conv_bcd, bcd_q;
  logic [CREDIT_W-1:0] last_q;
  logic                dirty_q;

  assign conv_start = ~conv_busy & (dirty_q | (shown_q != last_q));

  bin2bcd_seq #(
    .BIN_W  (CREDIT_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (shown_q),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q  <= '0;
      dirty_q <= 1'b0;
      bcd_q   <= '0;
    end else begin
      if (conv_start) begin
        last_q  <= shown_q;
        dirty_q <= 1'b0;
      end else if (conv_busy && (shown_d != shown_q)) begin
        dirty_q <= 1'b1;
      end
      if (conv_done) bcd_q <= conv_bcd;
    end
  end

  logic [RF_W-1:0]   ref_cnt_q;
  logic [IX_W-1:0]   idx_q;
  logic [DIGITS-1:0] blank;
  logic              zero_above;
  logic [3:0]        cur_digit;
  logic              cur_blank;
  logic [6:0]        seg_d, seg_q;
  logic [DIGITS-1:0] en_q;

  // Blank every digit above the most significant nonzero one; digit 0 always shows.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (bcd_q[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IX_W'(i)) begin
        cur_digit = bcd_q[4*i +: 4];
        cur_blank = blank[i];
      end
    end
    if (cur_blank || (cur_digit > 4'd9)) seg_d = SEG_BLANK;
    else                                 seg_d = SEG_LUT[cur_digit];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_cnt_q <= '0;
      idx_q     <= '0;
      seg_q     <= SEG_BLANK;
      en_q      <= '1;
    end else begin
      if (ref_cnt_q == REF_LAST) begin
        ref_cnt_q <= '0;
        idx_q     <= (idx_q == IDX_LAST) ? '0 : idx_q + IX_W'(1);
      end else begin
        ref_cnt_q <= ref_cnt_q + RF_W'(1);
      end
      seg_q <= seg_d;
      en_q  <= ~(DIGITS'(1) << idx_q);
    end
  end

  assign seven_segment_output = seg_q;
  assign digit_en             = en_q;
  assign win_active           = win_active_q;

endmodule
